// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared types and default widths for the AXI burst address generator.
package axi_burst_addr_gen_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int BOUNDARY_4K_BITS = 12;

  localparam int DEF_ID_WIDTH   = 6;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 1024;
  localparam int DEF_LEN_WIDTH  = 8;

  // Byte-lane index width; a 1-byte bus still gets a 1-bit lane field.
  function automatic int lane_width(input int data_width);
    int lw;
    lw = $clog2(data_width / 8);
    return (lw < 1) ? 1 : lw;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen_next_addr.sv
// Combinational beat arithmetic: lane window of the given address and the
// address of the following beat. WRAP arithmetic exists only with AXI_BURST_WRAP_EN.
module axi_next_addr
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  localparam int LANE_W    = lane_width(DATA_WIDTH)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  burst_t                burst,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [LANE_W-1:0]     lo,
  output logic [LANE_W-1:0]     hi
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] nb_mask;
  logic [ADDR_WIDTH-1:0] lane_sum;
  logic [ADDR_WIDTH-1:0] wrap_next;

`ifdef AXI_BURST_WRAP_EN
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] lower;
  logic [ADDR_WIDTH-1:0] wrap_step;

  always_comb begin
    span      = (ADDR_WIDTH'(len) + ONE) << size;
    lower     = addr & ~(span - ONE);
    wrap_step = addr + (ONE << size);
    wrap_next = (wrap_step == lower + span) ? lower : wrap_step;
  end
`else
  logic unused_len;
  assign unused_len = ^len;
  assign wrap_next  = '0;
`endif

  always_comb begin
    bytes    = ONE << size;
    aligned  = addr & ~(bytes - ONE);
    nb_mask  = ADDR_WIDTH'(NB - 1);
    // Lane window spans the whole naturally aligned beat, clipped at the start address.
    lane_sum = (aligned & nb_mask) + bytes - ONE;
    lo       = LANE_W'(addr & nb_mask);
    hi       = LANE_W'(lane_sum);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP: begin
`ifdef AXI_BURST_WRAP_EN
        next_addr = wrap_next;
`else
        next_addr = aligned + bytes;
`endif
      end
      default:     next_addr = aligned + bytes;
    endcase
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: one AW/AR command in, one beat descriptor per
// transfer out. AXI_BURST_WRAP_EN enables WRAP sequencing and WRAP legality checks.
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  localparam int LANE_W    = lane_width(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic [2:0]            i_cmd_size,
  input  logic [1:0]            i_cmd_burst,
  input  logic [ID_WIDTH-1:0]   i_cmd_id,
  output logic                  o_cmd_err,
  output logic                  o_beat_valid,
  input  logic                  i_beat_ready,
  output logic [ADDR_WIDTH-1:0] o_beat_addr,
  output logic [LANE_W-1:0]     o_beat_lo,
  output logic [LANE_W-1:0]     o_beat_hi,
  output logic [LEN_WIDTH-1:0]  o_beat_idx,
  output logic [ID_WIDTH-1:0]   o_beat_id,
  output logic                  o_beat_last
);

  localparam int LW = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  ONE_LEN = LEN_WIDTH'(1);

  state_t                state_reg;
  logic                  cmd_ready_reg;
  logic                  cmd_err_reg;
  logic                  beat_valid_reg;
  logic [ADDR_WIDTH-1:0] beat_addr_reg;
  logic [LANE_W-1:0]     beat_lo_reg;
  logic [LANE_W-1:0]     beat_hi_reg;
  logic [LEN_WIDTH-1:0]  beat_idx_reg;
  logic [ID_WIDTH-1:0]   beat_id_reg;
  logic                  beat_last_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [2:0]            size_reg;
  burst_t                burst_reg;

  burst_t                cmd_burst_eff;
  logic [ADDR_WIDTH-1:0] cmd_bytes;
  logic [ADDR_WIDTH-1:0] cmd_aligned;
  logic [ADDR_WIDTH-1:0] cmd_last_byte;
  logic                  cmd_cross_4k;
  logic                  cmd_illegal;

  // Reserved bursts, and WRAP when wrap support is compiled out, run as INCR.
  always_comb begin
    case (i_cmd_burst)
      2'd0:    cmd_burst_eff = BURST_FIXED;
`ifdef AXI_BURST_WRAP_EN
      2'd2:    cmd_burst_eff = BURST_WRAP;
`endif
      default: cmd_burst_eff = BURST_INCR;
    endcase
  end

  always_comb begin
    cmd_bytes     = ONE << i_cmd_size;
    cmd_aligned   = i_cmd_addr & ~(cmd_bytes - ONE);
    cmd_last_byte = cmd_aligned + ((ADDR_WIDTH'(i_cmd_len) + ONE) << i_cmd_size) - ONE;
    cmd_cross_4k  = cmd_aligned[ADDR_WIDTH-1:BOUNDARY_4K_BITS]
                    != cmd_last_byte[ADDR_WIDTH-1:BOUNDARY_4K_BITS];
    cmd_illegal   = (int'(i_cmd_size) > LW)
                  || (i_cmd_burst == 2'd3)
                  || ((cmd_burst_eff == BURST_INCR) && cmd_cross_4k);
`ifdef AXI_BURST_WRAP_EN
    if (i_cmd_burst == 2'd2) begin
      if (!((i_cmd_len == LEN_WIDTH'(1)) || (i_cmd_len == LEN_WIDTH'(3)) ||
            (i_cmd_len == LEN_WIDTH'(7)) || (i_cmd_len == LEN_WIDTH'(15))))
        cmd_illegal = 1'b1;
      if ((i_cmd_addr & (cmd_bytes - ONE)) != '0)
        cmd_illegal = 1'b1;
    end
`else
    if (i_cmd_burst == 2'd2)
      cmd_illegal = 1'b1;
`endif
  end

  // In IDLE the arithmetic looks at the incoming command so beat 0 is ready at acceptance.
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [2:0]            cur_size;
  burst_t                cur_burst;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [ADDR_WIDTH-1:0] step_addr;
  logic [LANE_W-1:0]     cur_lo;
  logic [LANE_W-1:0]     cur_hi;
  logic [LANE_W-1:0]     step_lo;
  logic [LANE_W-1:0]     step_hi;
  logic [ADDR_WIDTH-1:0] unused_step_next;

  always_comb begin
    if (state_reg == ST_IDLE) begin
      cur_addr  = i_cmd_addr;
      cur_size  = i_cmd_size;
      cur_burst = cmd_burst_eff;
      cur_len   = i_cmd_len;
    end else begin
      cur_addr  = beat_addr_reg;
      cur_size  = size_reg;
      cur_burst = burst_reg;
      cur_len   = len_reg;
    end
  end

  axi_next_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_cur (
    .addr      (cur_addr),
    .size      (cur_size),
    .burst     (cur_burst),
    .len       (cur_len),
    .next_addr (step_addr),
    .lo        (cur_lo),
    .hi        (cur_hi)
  );

  // Second copy supplies the lane window of the next beat so lanes stay registered.
  axi_next_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_step (
    .addr      (step_addr),
    .size      (cur_size),
    .burst     (cur_burst),
    .len       (cur_len),
    .next_addr (unused_step_next),
    .lo        (step_lo),
    .hi        (step_hi)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg      <= ST_IDLE;
      cmd_ready_reg  <= 1'b1;
      cmd_err_reg    <= 1'b0;
      beat_valid_reg <= 1'b0;
      beat_addr_reg  <= '0;
      beat_lo_reg    <= '0;
      beat_hi_reg    <= '0;
      beat_idx_reg   <= '0;
      beat_id_reg    <= '0;
      beat_last_reg  <= 1'b0;
      len_reg        <= '0;
      size_reg       <= '0;
      burst_reg      <= BURST_FIXED;
    end else begin
      cmd_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            state_reg      <= ST_BURST;
            cmd_ready_reg  <= 1'b0;
            cmd_err_reg    <= cmd_illegal;
            beat_valid_reg <= 1'b1;
            beat_addr_reg  <= i_cmd_addr;
            beat_lo_reg    <= cur_lo;
            beat_hi_reg    <= cur_hi;
            beat_idx_reg   <= '0;
            beat_id_reg    <= i_cmd_id;
            beat_last_reg  <= (i_cmd_len == '0);
            len_reg        <= i_cmd_len;
            size_reg       <= i_cmd_size;
            burst_reg      <= cmd_burst_eff;
          end
        end
        ST_BURST: begin
          if (i_beat_ready) begin
            if (beat_last_reg) begin
              state_reg      <= ST_IDLE;
              cmd_ready_reg  <= 1'b1;
              beat_valid_reg <= 1'b0;
              beat_last_reg  <= 1'b0;
            end else begin
              beat_addr_reg <= step_addr;
              beat_lo_reg   <= step_lo;
              beat_hi_reg   <= step_hi;
              beat_idx_reg  <= beat_idx_reg + ONE_LEN;
              beat_last_reg <= ((beat_idx_reg + ONE_LEN) == len_reg);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = cmd_ready_reg;
  assign o_cmd_err    = cmd_err_reg;
  assign o_beat_valid = beat_valid_reg;
  assign o_beat_addr  = beat_addr_reg;
  assign o_beat_lo    = beat_lo_reg;
  assign o_beat_hi    = beat_hi_reg;
  assign o_beat_idx   = beat_idx_reg;
  assign o_beat_id    = beat_id_reg;
  assign o_beat_last  = beat_last_reg;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen; WRAP expectations follow AXI_BURST_WRAP_EN.
module tb_axi_burst_addr_gen;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [31:0] i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic [2:0]  i_cmd_size;
  logic [1:0]  i_cmd_burst;
  logic [5:0]  i_cmd_id;
  logic        o_cmd_err;
  logic        o_beat_valid;
  logic        i_beat_ready;
  logic [31:0] o_beat_addr;
  logic [6:0]  o_beat_lo;
  logic [6:0]  o_beat_hi;
  logic [7:0]  o_beat_idx;
  logic [5:0]  o_beat_id;
  logic        o_beat_last;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ea  [0:15];
  logic [6:0]  elo [0:15];
  logic [6:0]  ehi [0:15];

  always #5 i_clk = ~i_clk;

  axi_burst_addr_gen dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_len    (i_cmd_len),
    .i_cmd_size   (i_cmd_size),
    .i_cmd_burst  (i_cmd_burst),
    .i_cmd_id     (i_cmd_id),
    .o_cmd_err    (o_cmd_err),
    .o_beat_valid (o_beat_valid),
    .i_beat_ready (i_beat_ready),
    .o_beat_addr  (o_beat_addr),
    .o_beat_lo    (o_beat_lo),
    .o_beat_hi    (o_beat_hi),
    .o_beat_idx   (o_beat_idx),
    .o_beat_id    (o_beat_id),
    .o_beat_last  (o_beat_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_exp(input int i, input logic [31:0] a, input logic [6:0] l, input logic [6:0] h);
    ea[i]  = a;
    elo[i] = l;
    ehi[i] = h;
  endtask

  task automatic check_beat(input string tag, input int i, input int len, input logic [5:0] id);
    check($sformatf("%s.valid%0d", tag, i), 64'(o_beat_valid), 64'(1));
    check($sformatf("%s.addr%0d", tag, i), 64'(o_beat_addr), 64'(ea[i]));
    check($sformatf("%s.lo%0d", tag, i), 64'(o_beat_lo), 64'(elo[i]));
    check($sformatf("%s.hi%0d", tag, i), 64'(o_beat_hi), 64'(ehi[i]));
    check($sformatf("%s.idx%0d", tag, i), 64'(o_beat_idx), 64'(i));
    check($sformatf("%s.last%0d", tag, i), 64'(o_beat_last), 64'(i == len));
    check($sformatf("%s.id%0d", tag, i), 64'(o_beat_id), 64'(id));
  endtask

  // Issues one command and walks its beats; optional stall or reset at a chosen beat.
  task automatic run_burst(input string tag, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [5:0] id, input logic exp_err,
                           input int stall_at, input int reset_at);
    int waited = 0;
    while (!o_cmd_ready && waited < 20) begin
      @(posedge i_clk); #1;
      waited++;
    end
    check({tag, ".cmd_ready"}, 64'(o_cmd_ready), 64'(1));
    if (!o_cmd_ready) return;
    i_cmd_addr   = addr;
    i_cmd_len    = 8'(len);
    i_cmd_size   = size;
    i_cmd_burst  = burst;
    i_cmd_id     = id;
    i_cmd_valid  = 1'b1;
    i_beat_ready = 1'b1;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    check({tag, ".err"}, 64'(o_cmd_err), 64'(exp_err));
    check({tag, ".busy"}, 64'(o_cmd_ready), 64'(0));
    for (int i = 0; i <= len; i++) begin
      if (i == reset_at) begin
        i_reset = 1'b1;
        #1;
        check({tag, ".rst_valid"}, 64'(o_beat_valid), 64'(0));
        @(posedge i_clk); #1;
        i_reset      = 1'b0;
        i_beat_ready = 1'b0;
        #1;
        check({tag, ".rst_ready"}, 64'(o_cmd_ready), 64'(1));
        check({tag, ".rst_valid_after"}, 64'(o_beat_valid), 64'(0));
        $display("%s: reset at beat %0d", tag, i);
        return;
      end
      if (i == stall_at) begin
        i_beat_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge i_clk); #1;
          check($sformatf("%s.stall_addr%0d", tag, s), 64'(o_beat_addr), 64'(ea[i]));
          check($sformatf("%s.stall_idx%0d", tag, s), 64'(o_beat_idx), 64'(i));
          check($sformatf("%s.stall_valid%0d", tag, s), 64'(o_beat_valid), 64'(1));
        end
        i_beat_ready = 1'b1;
      end
      check_beat(tag, i, len, id);
      if (i == 1) check({tag, ".err_end"}, 64'(o_cmd_err), 64'(0));
      $display("%s: beat %0d addr=0x%08h lo=%0d hi=%0d last=%0b", tag, i,
               o_beat_addr, o_beat_lo, o_beat_hi, o_beat_last);
      @(posedge i_clk); #1;
    end
    i_beat_ready = 1'b0;
    check({tag, ".bubble_valid"}, 64'(o_beat_valid), 64'(0));
    check({tag, ".bubble_ready"}, 64'(o_cmd_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset      = 1'b1;
    i_cmd_valid  = 1'b0;
    i_cmd_addr   = '0;
    i_cmd_len    = '0;
    i_cmd_size   = '0;
    i_cmd_burst  = '0;
    i_cmd_id     = '0;
    i_beat_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    #1;
    check("rst.cmd_ready", 64'(o_cmd_ready), 64'(1));
    check("rst.valid", 64'(o_beat_valid), 64'(0));
    check("rst.err", 64'(o_cmd_err), 64'(0));
    check("rst.addr", 64'(o_beat_addr), 64'(0));
    check("rst.lo", 64'(o_beat_lo), 64'(0));
    check("rst.hi", 64'(o_beat_hi), 64'(0));
    check("rst.idx", 64'(o_beat_idx), 64'(0));
    check("rst.id", 64'(o_beat_id), 64'(0));
    check("rst.last", 64'(o_beat_last), 64'(0));
    @(posedge i_clk); #1;

    // INCR aligned, with a 5-cycle stall on beat 2
    set_exp(0, 32'h1004, 7'd4, 7'd7);
    set_exp(1, 32'h1008, 7'd8, 7'd11);
    set_exp(2, 32'h100C, 7'd12, 7'd15);
    set_exp(3, 32'h1010, 7'd16, 7'd19);
    run_burst("incr", 32'h1004, 3, 3'd2, 2'd1, 6'd5, 1'b0, 2, -1);

    // WRAP back-to-back
`ifdef AXI_BURST_WRAP_EN
    set_exp(0, 32'h1038, 7'd56, 7'd63);
    set_exp(1, 32'h1020, 7'd32, 7'd39);
    set_exp(2, 32'h1028, 7'd40, 7'd47);
    set_exp(3, 32'h1030, 7'd48, 7'd55);
    run_burst("wrap", 32'h1038, 3, 3'd3, 2'd2, 6'd9, 1'b0, -1, -1);
`else
    set_exp(0, 32'h1038, 7'd56, 7'd63);
    set_exp(1, 32'h1040, 7'd64, 7'd71);
    set_exp(2, 32'h1048, 7'd72, 7'd79);
    set_exp(3, 32'h1050, 7'd80, 7'd87);
    run_burst("wrap", 32'h1038, 3, 3'd3, 2'd2, 6'd9, 1'b1, -1, -1);
`endif

    // Unaligned INCR start
    set_exp(0, 32'h1003, 7'd3, 7'd3);
    set_exp(1, 32'h1004, 7'd4, 7'd7);
    run_burst("unal", 32'h1003, 1, 3'd2, 2'd1, 6'd17, 1'b0, -1, -1);

    // INCR crossing 4 KB
    set_exp(0, 32'h0FF0, 7'd112, 7'd127);
    set_exp(1, 32'h1000, 7'd0, 7'd15);
    run_burst("x4k", 32'h0FF0, 1, 3'd4, 2'd1, 6'd33, 1'b1, -1, -1);

    // FIXED repeats the start address and lanes
    set_exp(0, 32'h0104, 7'd4, 7'd5);
    set_exp(1, 32'h0104, 7'd4, 7'd5);
    set_exp(2, 32'h0104, 7'd4, 7'd5);
    run_burst("fixed", 32'h0104, 2, 3'd1, 2'd0, 6'd2, 1'b0, 1, -1);

    // Reserved burst runs as INCR with an error pulse
    set_exp(0, 32'h0200, 7'd0, 7'd3);
    set_exp(1, 32'h0204, 7'd4, 7'd7);
    run_burst("rsvd", 32'h0200, 1, 3'd2, 2'd3, 6'd63, 1'b1, -1, -1);

    // Reset at beat 2 of an 8-beat INCR burst
    set_exp(0, 32'h2000, 7'd0, 7'd3);
    set_exp(1, 32'h2004, 7'd4, 7'd7);
    set_exp(2, 32'h2008, 7'd8, 7'd11);
    run_burst("rstmid", 32'h2000, 7, 3'd2, 2'd1, 6'd7, 1'b0, -1, 2);

    // Next command after reset starts from idx 0
    set_exp(0, 32'h3000, 7'd0, 7'd0);
    run_burst("post", 32'h3000, 0, 3'd0, 2'd1, 6'd12, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
